pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised next-generation fetch PC generator for the core front end.
- Produces the fetch address each cycle with a valid/ready handshake toward IF.
- Arbitrates redirect sources with fixed priority: trap, then EX mispredict correction, then internal BTB prediction, then sequential.
- Contains a direct-mapped BTB with 2-bit saturating counters, trained from EX.
- Redirects are honoured even while fetch is stalled.

Parameters:
- ADDR_W, 32, width of all instruction addresses.
- RESET_ADDR, 32'h0000_0000, first fetch address after reset (low 2 bits must be 0).
- BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256.
- IDX_W, log2(BTB_ENTRIES), derived BTB index width (localparam).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset
- hold_i  in  1  pipeline stall from ctrl; freezes sequential/predicted advance
- if_ready_i  in  1  IF stage accepts pc_o this cycle
- trap_en_i  in  1  trap/exception redirect request
- trap_addr_i  in  ADDR_W  trap vector
- ex_redirect_en_i  in  1  EX mispredict correction request
- ex_redirect_addr_i  in  ADDR_W  corrected next PC
- ex_upd_en_i  in  1  BTB training strobe (resolved branch/jump in EX)
- ex_upd_pc_i  in  ADDR_W  PC of the resolved instruction
- ex_upd_target_i  in  ADDR_W  resolved target
- ex_upd_taken_i  in  1  resolved direction
- pc_o  out  ADDR_W  current fetch address
- pc_valid_o  out  1  pc_o is valid for fetch
- pred_taken_o  out  1  BTB predicts pc_o as taken (travels with the instruction)
- pred_target_o  out  ADDR_W  predicted target for pc_o

Behaviour:
- Reset: a rising edge with rstn=0 sets pc_o=RESET_ADDR, pc_valid_o=0, state=BOOT, and clears all BTB valid bits. BTB targets and counters are not reset. Reset wins over every other input.
- FSM states:
  - BOOT: pc_valid_o=0; moves to RUN on the next edge; pc_o holds RESET_ADDR.
  - RUN: pc_valid_o=1. There is no other state.
- Advance condition: adv = pc_valid_o & if_ready_i & ~hold_i.
- Next-PC priority, applied in RUN and registered (one-cycle latency):
  1. trap_en_i: pc_o <= trap_addr_i.
  2. ex_redirect_en_i: pc_o <= ex_redirect_addr_i.
  3. ~adv: pc_o holds.
  4. pred_taken_o: pc_o <= pred_target_o.
  5. Otherwise: pc_o <= pc_o + 4, modulo 2^ADDR_W.
- Redirects in BOOT: trap and redirect are also honoured in BOOT. pc_o is updated and the FSM still goes to RUN.
- Alignment: bits [1:0] of every address loaded into pc_o or stored in the BTB are forced to 0.
- BTB entry fields: valid, tag = addr[ADDR_W-1:IDX_W+2], target[ADDR_W-1:2], ctr[1:0]. Index = addr[IDX_W+1:2].
- Lookup is combinational on pc_o:
  - hit = valid & tag match.
  - pred_taken_o = pc_valid_o & hit & ctr[1].
  - pred_target_o = stored target when hit, else pc_o + 4.
- Update on ex_upd_en_i, written at the edge:
  - Hit, taken: ctr saturating +1 (max 2'b11); target <= ex_upd_target_i.
  - Hit, not taken: ctr saturating -1 (min 2'b00); target unchanged.
  - Miss, taken: allocate/overwrite with valid=1, new tag and target, ctr=2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup uses pre-update contents. The new contents are visible the following cycle.
- Updates are accepted regardless of hold_i, trap or redirect.
- Redirect while stalled: trap or ex_redirect with hold_i=1 or if_ready_i=0 still loads pc_o. It is not lost or delayed.
- Wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000; prediction is unaffected.
- Reset mid-operation: the next edge with rstn=0 discards any pending state and returns to the reset values above.

Test Plan:
- Reset/boot: hold rstn=0 for 3 cycles, release, if_ready_i=1 -> pc_o=0 with pc_valid_o=0 for one cycle, then pc_o=0,4,8,12 with pc_valid_o=1.
- Stall and redirect: at pc_o=0x20 set hold_i=1 for 3 cycles -> pc_o holds 0x20. During the hold, pulse ex_redirect_en_i with 0x80 -> pc_o=0x80 next cycle, still held. Release hold -> 0x84.
- Priority: same cycle trap_en_i (0x100) and ex_redirect_en_i (0x200) -> pc_o=0x100. Unaligned trap_addr_i 0x103 -> pc_o=0x100.
- BTB train and predict: ex_upd pc=0x10, target=0x400, taken -> next fetch of 0x10 gives pred_taken_o=1, pred_target_o=0x400, and the next pc_o=0x400.
- BTB untrain and conflict:
  - From ctr=2'b10, one not-taken update on 0x10 -> ctr=2'b01; 0x10 then predicts not taken and the next pc_o=0x14.
  - A taken update on aliasing address 0x10+4*BTB_ENTRIES evicts the 0x10 entry.
- Wrap and update collision: pc_o=0xFFFF_FFFC -> next pc_o=0x0. Update to the current lookup index in the same cycle -> old prediction that cycle, new prediction the following cycle.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: registered next-PC selection (trap > EX redirect > stall > BTB > +4)
// with a direct-mapped BTB of 2-bit saturating counters trained from EX.
module pc_gen #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = 32'h0000_0000,
   parameter int                BTB_ENTRIES = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              hold_i,
   input  logic              if_ready_i,
   input  logic              trap_en_i,
   input  logic [ADDR_W-1:0] trap_addr_i,
   input  logic              ex_redirect_en_i,
   input  logic [ADDR_W-1:0] ex_redirect_addr_i,
   input  logic              ex_upd_en_i,
   input  logic [ADDR_W-1:0] ex_upd_pc_i,
   input  logic [ADDR_W-1:0] ex_upd_target_i,
   input  logic              ex_upd_taken_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              pred_taken_o,
   output logic [ADDR_W-1:0] pred_target_o
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam int TGT_W = ADDR_W - 2;
   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      logic [1:0] r;
      case (c)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b11;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      logic [1:0] r;
      case (c)
         2'b00:   r = 2'b00;
         2'b01:   r = 2'b00;
         2'b10:   r = 2'b01;
         2'b11:   r = 2'b10;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                pc_valid_q, pc_valid_d;
   logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
   logic [TAG_W-1:0]    btb_tag_q [BTB_ENTRIES];
   logic [TGT_W-1:0]    btb_tgt_q [BTB_ENTRIES];
   logic [1:0]          btb_ctr_q [BTB_ENTRIES];

   logic [IDX_W-1:0]    lk_idx_s;
   logic                lk_hit_s;
   logic [ADDR_W-1:0]   pc_inc_s;
   logic                adv_s;
   logic [IDX_W-1:0]    up_idx_s;
   logic [TAG_W-1:0]    up_tag_s;
   logic                up_hit_s;
   logic                btb_we_s;
   logic [TAG_W-1:0]    new_tag_s;
   logic [TGT_W-1:0]    new_tgt_s;
   logic [1:0]          new_ctr_s;
   logic                unused_s;

   assign unused_s = ^{trap_addr_i[1:0], ex_redirect_addr_i[1:0],
                       ex_upd_pc_i[1:0], ex_upd_target_i[1:0]};

   // BTB lookup on the current fetch address (pre-update contents)
   always_comb begin
      lk_idx_s      = pc_q[IDX_W+1:2];
      pc_inc_s      = pc_q + PC_INC;
      lk_hit_s      = btb_valid_q[lk_idx_s] & (btb_tag_q[lk_idx_s] == pc_q[ADDR_W-1:IDX_W+2]);
      pred_taken_o  = pc_valid_q & lk_hit_s & btb_ctr_q[lk_idx_s][1];
      if (lk_hit_s) begin
         pred_target_o = {btb_tgt_q[lk_idx_s], 2'b00};
      end else begin
         pred_target_o = pc_inc_s;
      end
   end

   // Next-PC selection; redirects bypass the stall and also apply in BOOT
   always_comb begin
      adv_s      = pc_valid_q & if_ready_i & ~hold_i;
      pc_d       = pc_q;
      state_d    = RUN;
      pc_valid_d = 1'b1;
      if (trap_en_i) begin
         pc_d = {trap_addr_i[ADDR_W-1:2], 2'b00};
      end else if (ex_redirect_en_i) begin
         pc_d = {ex_redirect_addr_i[ADDR_W-1:2], 2'b00};
      end else if (!adv_s) begin
         pc_d = pc_q;
      end else if (pred_taken_o) begin
         pc_d = pred_target_o;
      end else begin
         pc_d = pc_inc_s;
      end
   end

   // BTB training: decide whether and what to write at the resolved index
   always_comb begin
      up_idx_s    = ex_upd_pc_i[IDX_W+1:2];
      up_tag_s    = ex_upd_pc_i[ADDR_W-1:IDX_W+2];
      up_hit_s    = btb_valid_q[up_idx_s] & (btb_tag_q[up_idx_s] == up_tag_s);
      btb_valid_d = btb_valid_q;
      btb_we_s    = 1'b0;
      new_tag_s   = btb_tag_q[up_idx_s];
      new_tgt_s   = btb_tgt_q[up_idx_s];
      new_ctr_s   = btb_ctr_q[up_idx_s];
      if (ex_upd_en_i) begin
         if (up_hit_s) begin
            btb_we_s = 1'b1;
            if (ex_upd_taken_i) begin
               new_ctr_s = ctr_inc(btb_ctr_q[up_idx_s]);
               new_tgt_s = ex_upd_target_i[ADDR_W-1:2];
            end else begin
               new_ctr_s = ctr_dec(btb_ctr_q[up_idx_s]);
            end
         end else if (ex_upd_taken_i) begin
            btb_we_s              = 1'b1;
            btb_valid_d[up_idx_s] = 1'b1;
            new_tag_s             = up_tag_s;
            new_tgt_s             = ex_upd_target_i[ADDR_W-1:2];
            new_ctr_s             = 2'b10;
         end else begin
            btb_we_s = 1'b0;
         end
      end else begin
         btb_we_s = 1'b0;
      end
   end

   // FSM, fetch PC and BTB valid bits; reset overrides everything
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= BOOT;
         pc_q        <= {RESET_ADDR[ADDR_W-1:2], 2'b00};
         pc_valid_q  <= 1'b0;
         btb_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pc_valid_q  <= pc_valid_d;
         btb_valid_q <= btb_valid_d;
      end
   end

   // BTB payload storage, intentionally not reset (guarded by the valid bits)
   always_ff @(posedge clk) begin
      if (btb_we_s) begin
         btb_tag_q[up_idx_s] <= new_tag_s;
         btb_tgt_q[up_idx_s] <= new_tgt_s;
         btb_ctr_q[up_idx_s] <= new_ctr_s;
      end
   end

   assign pc_o       = pc_q;
   assign pc_valid_o = pc_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen (default parameters, 16-entry BTB).
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rstn;
   logic        hold_i, if_ready_i, trap_en_i, ex_redirect_en_i;
   logic        ex_upd_en_i, ex_upd_taken_i;
   logic [31:0] trap_addr_i, ex_redirect_addr_i, ex_upd_pc_i, ex_upd_target_i;
   logic [31:0] pc_o, pred_target_o;
   logic        pc_valid_o, pred_taken_o;

   int n_vec = 0;
   int n_bad = 0;

   pc_gen dut (
      .clk(clk), .rstn(rstn), .hold_i(hold_i), .if_ready_i(if_ready_i),
      .trap_en_i(trap_en_i), .trap_addr_i(trap_addr_i),
      .ex_redirect_en_i(ex_redirect_en_i), .ex_redirect_addr_i(ex_redirect_addr_i),
      .ex_upd_en_i(ex_upd_en_i), .ex_upd_pc_i(ex_upd_pc_i),
      .ex_upd_target_i(ex_upd_target_i), .ex_upd_taken_i(ex_upd_taken_i),
      .pc_o(pc_o), .pc_valid_o(pc_valid_o),
      .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hold, rdy, te;
      logic [31:0] ta;
      logic        re;
      logic [31:0] ra;
      logic        ue;
      logic [31:0] upc, utg;
      logic        utk;
      logic [31:0] e_pc;
      logic        e_v, e_pt;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic hold, input logic rdy,
                               input logic te, input logic [31:0] ta,
                               input logic re, input logic [31:0] ra,
                               input logic ue, input logic [31:0] upc,
                               input logic [31:0] utg, input logic utk,
                               input logic [31:0] e_pc, input logic e_v,
                               input logic e_pt, input logic [31:0] e_tgt);
      vec_t v;
      v.hold = hold; v.rdy = rdy; v.te = te; v.ta = ta; v.re = re; v.ra = ra;
      v.ue = ue; v.upc = upc; v.utg = utg; v.utk = utk;
      v.e_pc = e_pc; v.e_v = e_v; v.e_pt = e_pt; v.e_tgt = e_tgt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      hold_i = v.hold; if_ready_i = v.rdy;
      trap_en_i = v.te; trap_addr_i = v.ta;
      ex_redirect_en_i = v.re; ex_redirect_addr_i = v.ra;
      ex_upd_en_i = v.ue; ex_upd_pc_i = v.upc;
      ex_upd_target_i = v.utg; ex_upd_taken_i = v.utk;
   endtask

   task automatic check(input string nm, input logic [31:0] e_pc, input logic e_v,
                        input logic e_pt, input logic [31:0] e_tgt);
      n_vec++;
      if (pc_o !== e_pc) begin
         n_bad++;
         $display("FAIL %s pc_o got %h want %h", nm, pc_o, e_pc);
      end
      if (pc_valid_o !== e_v) begin
         n_bad++;
         $display("FAIL %s pc_valid_o got %b want %b", nm, pc_valid_o, e_v);
      end
      if (pred_taken_o !== e_pt) begin
         n_bad++;
         $display("FAIL %s pred_taken_o got %b want %b", nm, pred_taken_o, e_pt);
      end
      if (pred_target_o !== e_tgt) begin
         n_bad++;
         $display("FAIL %s pred_target_o got %h want %h", nm, pred_target_o, e_tgt);
      end
   endtask

   localparam logic [31:0] Z = 32'h0;

   initial begin
      //             hold  rdy   te    ta            re    ra            ue    upc           utg           utk   e_pc          v     pt    tgt
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0000,1'b1,1'b0,32'h0000_0004)); // boot->run
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0004,1'b1,1'b0,32'h0000_0008));
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0008,1'b1,1'b0,32'h0000_000C));
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_000C,1'b1,1'b0,32'h0000_0010));
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b1,32'h10,      32'h400,     1'b1, 32'h0000_0010,1'b1,1'b1,32'h0000_0400)); // train
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0400,1'b1,1'b0,32'h0000_0404)); // predicted
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b1,32'h10,      1'b0,Z,           Z,           1'b0, 32'h0000_0010,1'b1,1'b1,32'h0000_0400));
      tbl.push_back(mk(1'b1,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0010,1'b1,1'b1,32'h0000_0400)); // hold
      tbl.push_back(mk(1'b1,1'b1, 1'b0,Z,           1'b0,Z,           1'b1,32'h10,      Z,           1'b0, 32'h0000_0010,1'b1,1'b0,32'h0000_0400)); // untrain
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0014,1'b1,1'b0,32'h0000_0018));
      tbl.push_back(mk(1'b0,1'b1, 1'b1,32'h100,     1'b1,32'h200,     1'b0,Z,           Z,           1'b0, 32'h0000_0100,1'b1,1'b0,32'h0000_0104)); // priority
      tbl.push_back(mk(1'b0,1'b1, 1'b1,32'h103,     1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0100,1'b1,1'b0,32'h0000_0104)); // unaligned
      tbl.push_back(mk(1'b0,1'b0, 1'b0,Z,           1'b1,32'h207,     1'b0,Z,           Z,           1'b0, 32'h0000_0204,1'b1,1'b0,32'h0000_0208)); // redirect, not ready
      tbl.push_back(mk(1'b0,1'b0, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0204,1'b1,1'b0,32'h0000_0208));
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b1,32'h10,      32'h300,     1'b1, 32'h0000_0208,1'b1,1'b0,32'h0000_020C)); // retrain
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b1,32'h10,      1'b0,Z,           Z,           1'b0, 32'h0000_0010,1'b1,1'b1,32'h0000_0300));
      tbl.push_back(mk(1'b1,1'b1, 1'b0,Z,           1'b0,Z,           1'b1,32'h50,      32'h500,     1'b1, 32'h0000_0010,1'b1,1'b0,32'h0000_0014)); // alias evict
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b1,32'h50,      1'b0,Z,           Z,           1'b0, 32'h0000_0050,1'b1,1'b1,32'h0000_0500));
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0500,1'b1,1'b0,32'h0000_0504));
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b1,32'h50,      32'h500,     1'b1, 32'h0000_0504,1'b1,1'b0,32'h0000_0508)); // ctr 11
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b1,32'h50,      32'h500,     1'b1, 32'h0000_0508,1'b1,1'b0,32'h0000_050C)); // saturate
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b1,32'h50,      1'b1,32'h50,      Z,           1'b0, 32'h0000_0050,1'b1,1'b1,32'h0000_0500)); // ctr 10
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b1,32'hFFFF_FFFC,1'b0,Z,          Z,           1'b0, 32'hFFFF_FFFC,1'b1,1'b0,32'h0000_0000));
      tbl.push_back(mk(1'b0,1'b1, 1'b0,Z,           1'b0,Z,           1'b0,Z,           Z,           1'b0, 32'h0000_0000,1'b1,1'b0,32'h0000_0004)); // wrap

      rstn = 1'b0;
      drive(mk(1'b0,1'b1,1'b0,Z,1'b0,Z,1'b0,Z,Z,1'b0,Z,1'b0,1'b0,Z));
      repeat (3) @(negedge clk);
      check("reset", 32'h0, 1'b0, 1'b0, 32'h4);

      rstn = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         @(negedge clk);
         check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_pt, tbl[i].e_tgt);
      end

      // same-cycle update to the index being looked up
      hold_i = 1'b1; ex_upd_en_i = 1'b1; ex_upd_pc_i = 32'h0;
      ex_upd_target_i = 32'h600; ex_upd_taken_i = 1'b1;
      #1;
      check("coll_old", 32'h0, 1'b1, 1'b0, 32'h4);
      @(negedge clk);
      ex_upd_en_i = 1'b0;
      check("coll_new", 32'h0, 1'b1, 1'b1, 32'h600);
      hold_i = 1'b0;
      @(negedge clk);
      check("coll_follow", 32'h600, 1'b1, 1'b0, 32'h604);

      // reset mid-run beats a trap, then a trap taken in BOOT
      rstn = 1'b0; trap_en_i = 1'b1; trap_addr_i = 32'h40;
      @(negedge clk);
      check("mid_reset", 32'h0, 1'b0, 1'b0, 32'h4);
      rstn = 1'b1;
      @(negedge clk);
      check("boot_trap", 32'h40, 1'b1, 1'b0, 32'h44);
      trap_en_i = 1'b0;
      @(negedge clk);
      check("post_trap", 32'h44, 1'b1, 1'b0, 32'h48);
      ex_redirect_en_i = 1'b1; ex_redirect_addr_i = 32'h0;
      @(negedge clk);
      ex_redirect_en_i = 1'b0;
      check("btb_cleared", 32'h0, 1'b1, 1'b0, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
